// File: rtl/cu_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : e_gpu_arb_pkg
// Purpose  : Shared types and helpers for the compute-unit to L2 arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package e_gpu_arb_pkg;

    // Source-ID width; a single requester still carries one ID bit.
    function automatic int sel_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int ARB_NUM_CU = 4;
    localparam int ARB_ADDR_W = 26;
    localparam int ARB_DATA_W = 512;
    localparam int ARB_TAG_W  = 8;
    localparam int ARB_SEL_W  = sel_width(ARB_NUM_CU);

    typedef struct packed {
        logic                            rw;
        logic [ARB_ADDR_W-1:0]           addr;
        logic [ARB_DATA_W/8-1:0]         byteen;
        logic [ARB_DATA_W-1:0]           data;
        logic [ARB_TAG_W+ARB_SEL_W-1:0]  tag;
    } req_payload_t;

    typedef struct packed {
        logic [ARB_DATA_W-1:0] data;
        logic [ARB_TAG_W-1:0]  tag;
    } rsp_payload_t;

endpackage
`default_nettype wire

// File: rtl/cu_mem_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin pick starting at ptr_i.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_CU = 4,
    parameter int SEL_W  = 2
) (
    input  logic [NUM_CU-1:0] valid_i,
    input  logic [SEL_W-1:0]  ptr_i,
    output logic [NUM_CU-1:0] grant_o,
    output logic [SEL_W-1:0]  grant_idx_o,
    output logic              any_valid_o
);

    always_comb begin
        int idx;
        grant_o     = '0;
        grant_idx_o = '0;
        any_valid_o = 1'b0;
        idx         = 0;
        for (int off = 0; off < NUM_CU; off++) begin
            idx = (int'(ptr_i) + off) % NUM_CU;
            if (!any_valid_o && valid_i[idx]) begin
                any_valid_o  = 1'b1;
                grant_o[idx] = 1'b1;
                grant_idx_o  = SEL_W'(idx);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/cu_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cu_mem_arbiter
// Purpose  : Round-robin share of one L2 port among NUM_CU requesters, with
//            one registered request slot and one registered response slot.
// Revision : 1.0 - initial release
// ============================================================================
module cu_mem_arbiter
    import e_gpu_arb_pkg::*;
#(
    parameter int  NUM_CU = 4,
    parameter int  ADDR_W = 26,
    parameter int  DATA_W = 512,
    parameter int  TAG_W  = 8,
    localparam int SEL_W  = sel_width(NUM_CU)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NUM_CU-1:0]          cu_req_valid_i,
    input  logic [NUM_CU-1:0]          cu_req_rw_i,
    input  logic [NUM_CU*ADDR_W-1:0]   cu_req_addr_i,
    input  logic [NUM_CU*DATA_W/8-1:0] cu_req_byteen_i,
    input  logic [NUM_CU*DATA_W-1:0]   cu_req_data_i,
    input  logic [NUM_CU*TAG_W-1:0]    cu_req_tag_i,
    output logic [NUM_CU-1:0]          cu_req_ready_o,
    output logic                       l2_req_valid_o,
    output logic                       l2_req_rw_o,
    output logic [ADDR_W-1:0]          l2_req_addr_o,
    output logic [DATA_W/8-1:0]        l2_req_byteen_o,
    output logic [DATA_W-1:0]          l2_req_data_o,
    output logic [TAG_W+SEL_W-1:0]     l2_req_tag_o,
    input  logic                       l2_req_ready_i,
    input  logic                       l2_rsp_valid_i,
    input  logic [DATA_W-1:0]          l2_rsp_data_i,
    input  logic [TAG_W+SEL_W-1:0]     l2_rsp_tag_i,
    output logic                       l2_rsp_ready_o,
    output logic [NUM_CU-1:0]          cu_rsp_valid_o,
    output logic [DATA_W-1:0]          cu_rsp_data_o,
    output logic [TAG_W-1:0]           cu_rsp_tag_o,
    input  logic [NUM_CU-1:0]          cu_rsp_ready_i,
    output logic                       err_o
);

    localparam int BE_W   = DATA_W / 8;
    localparam int OTAG_W = TAG_W + SEL_W;

    typedef struct packed {
        logic              rw;
        logic [ADDR_W-1:0] addr;
        logic [BE_W-1:0]   byteen;
        logic [DATA_W-1:0] data;
        logic [OTAG_W-1:0] tag;
    } req_slot_t;

    // The full tag is kept so the slot itself knows its destination.
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [OTAG_W-1:0] tag;
    } rsp_slot_t;

    logic              req_valid_q, req_valid_d;
    req_slot_t         req_q, req_d;
    logic [SEL_W-1:0]  ptr_q, ptr_d;
    logic              rsp_valid_q, rsp_valid_d;
    rsp_slot_t         rsp_q, rsp_d;
    logic              err_q, err_d;

    logic [NUM_CU-1:0] grant;
    logic [SEL_W-1:0]  win;
    logic              any_valid;
    logic              can_accept;
    logic              accept;
    logic [SEL_W-1:0]  dest;
    logic [SEL_W-1:0]  in_id;
    logic              in_range;
    logic              rsp_fire;

    rr_arbiter #(
        .NUM_CU (NUM_CU),
        .SEL_W  (SEL_W)
    ) u_rr_arbiter (
        .valid_i     (cu_req_valid_i),
        .ptr_i       (ptr_q),
        .grant_o     (grant),
        .grant_idx_o (win),
        .any_valid_o (any_valid)
    );

    always_comb begin
        can_accept     = !req_valid_q || l2_req_ready_i;
        accept         = can_accept && any_valid;
        cu_req_ready_o = can_accept ? grant : '0;
        req_valid_d    = req_valid_q && !l2_req_ready_i;
        req_d          = req_q;
        ptr_d          = ptr_q;
        if (accept) begin
            req_valid_d  = 1'b1;
            req_d.rw     = cu_req_rw_i[win];
            req_d.addr   = cu_req_addr_i[int'(win)*ADDR_W +: ADDR_W];
            req_d.byteen = cu_req_byteen_i[int'(win)*BE_W +: BE_W];
            req_d.data   = cu_req_data_i[int'(win)*DATA_W +: DATA_W];
            req_d.tag    = {win, cu_req_tag_i[int'(win)*TAG_W +: TAG_W]};
            ptr_d        = (int'(win) == NUM_CU - 1) ? '0 : win + SEL_W'(1);
        end
    end

    always_comb begin
        dest           = rsp_q.tag[OTAG_W-1 -: SEL_W];
        in_id          = l2_rsp_tag_i[OTAG_W-1 -: SEL_W];
        in_range       = 32'(in_id) < 32'(NUM_CU);
        l2_rsp_ready_o = !rsp_valid_q || cu_rsp_ready_i[dest];
        rsp_fire       = l2_rsp_valid_i && l2_rsp_ready_o;
        rsp_valid_d    = rsp_valid_q && !cu_rsp_ready_i[dest];
        rsp_d          = rsp_q;
        err_d          = err_q;
        if (rsp_fire) begin
            if (in_range) begin
                rsp_valid_d = 1'b1;
                rsp_d.data  = l2_rsp_data_i;
                rsp_d.tag   = l2_rsp_tag_i;
            end else begin
                // Unroutable response is consumed so L2 never stalls on it.
                err_d = 1'b1;
            end
        end
        cu_rsp_valid_o = '0;
        for (int i = 0; i < NUM_CU; i++) begin
            if (rsp_valid_q && (int'(dest) == i)) begin
                cu_rsp_valid_o[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            req_valid_q <= 1'b0;
            req_q       <= '0;
            ptr_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            req_valid_q <= req_valid_d;
            req_q       <= req_d;
            ptr_q       <= ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_q       <= rsp_d;
            err_q       <= err_d;
        end
    end

    assign l2_req_valid_o  = req_valid_q;
    assign l2_req_rw_o     = req_q.rw;
    assign l2_req_addr_o   = req_q.addr;
    assign l2_req_byteen_o = req_q.byteen;
    assign l2_req_data_o   = req_q.data;
    assign l2_req_tag_o    = req_q.tag;
    assign cu_rsp_data_o   = rsp_q.data;
    assign cu_rsp_tag_o    = rsp_q.tag[TAG_W-1:0];
    assign err_o           = err_q;

endmodule
`default_nettype wire

// File: tb/tb_cu_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cu_mem_arbiter
// Purpose  : Directed scoreboard bench for cu_mem_arbiter (4-CU and 5-CU builds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cu_mem_arbiter;
    import e_gpu_arb_pkg::*;

    localparam int N   = ARB_NUM_CU;
    localparam int AW  = ARB_ADDR_W;
    localparam int DW  = ARB_DATA_W;
    localparam int TW  = ARB_TAG_W;
    localparam int SW  = ARB_SEL_W;
    localparam int BW  = DW / 8;
    localparam int OTW = TW + SW;
    localparam int N5  = 5;
    localparam int DW5 = 32;
    localparam int SW5 = 3;

    typedef struct packed {
        logic [SW-1:0] dest;
        rsp_payload_t  p;
    } rsp_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [N-1:0]    cu_req_valid, cu_req_rw, cu_req_ready;
    logic [N*AW-1:0] cu_req_addr;
    logic [N*BW-1:0] cu_req_byteen;
    logic [N*DW-1:0] cu_req_data;
    logic [N*TW-1:0] cu_req_tag;
    logic            l2_req_valid, l2_req_rw, l2_req_ready;
    logic [AW-1:0]   l2_req_addr;
    logic [BW-1:0]   l2_req_byteen;
    logic [DW-1:0]   l2_req_data;
    logic [OTW-1:0]  l2_req_tag;
    logic            l2_rsp_valid, l2_rsp_ready;
    logic [DW-1:0]   l2_rsp_data;
    logic [OTW-1:0]  l2_rsp_tag;
    logic [N-1:0]    cu_rsp_valid, cu_rsp_ready;
    logic [DW-1:0]   cu_rsp_data;
    logic [TW-1:0]   cu_rsp_tag;
    logic            err;

    logic [N5-1:0]       d5_req_zero, d5_cu_req_ready, d5_cu_rsp_valid, d5_cu_rsp_ready;
    logic [N5*AW-1:0]    d5_addr_zero;
    logic [N5*DW5/8-1:0] d5_be_zero;
    logic [N5*DW5-1:0]   d5_data_zero;
    logic [N5*TW-1:0]    d5_tag_zero;
    logic                d5_l2_req_valid, d5_l2_req_rw, d5_l2_rsp_valid, d5_l2_rsp_ready, d5_err;
    logic [AW-1:0]       d5_l2_req_addr;
    logic [DW5/8-1:0]    d5_l2_req_byteen;
    logic [DW5-1:0]      d5_l2_req_data, d5_l2_rsp_data, d5_cu_rsp_data;
    logic [TW+SW5-1:0]   d5_l2_req_tag, d5_l2_rsp_tag;
    logic [TW-1:0]       d5_cu_rsp_tag;

    req_payload_t exp_req_q[$];
    rsp_exp_t     exp_rsp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    cu_mem_arbiter #(.NUM_CU(N), .ADDR_W(AW), .DATA_W(DW), .TAG_W(TW)) u_dut (
        .clk_i(clk), .rst_i(rst),
        .cu_req_valid_i(cu_req_valid), .cu_req_rw_i(cu_req_rw), .cu_req_addr_i(cu_req_addr),
        .cu_req_byteen_i(cu_req_byteen), .cu_req_data_i(cu_req_data), .cu_req_tag_i(cu_req_tag),
        .cu_req_ready_o(cu_req_ready),
        .l2_req_valid_o(l2_req_valid), .l2_req_rw_o(l2_req_rw), .l2_req_addr_o(l2_req_addr),
        .l2_req_byteen_o(l2_req_byteen), .l2_req_data_o(l2_req_data), .l2_req_tag_o(l2_req_tag),
        .l2_req_ready_i(l2_req_ready),
        .l2_rsp_valid_i(l2_rsp_valid), .l2_rsp_data_i(l2_rsp_data), .l2_rsp_tag_i(l2_rsp_tag),
        .l2_rsp_ready_o(l2_rsp_ready),
        .cu_rsp_valid_o(cu_rsp_valid), .cu_rsp_data_o(cu_rsp_data), .cu_rsp_tag_o(cu_rsp_tag),
        .cu_rsp_ready_i(cu_rsp_ready), .err_o(err)
    );

    // Five requesters give a 3-bit ID, so IDs 5..7 are unroutable.
    cu_mem_arbiter #(.NUM_CU(N5), .ADDR_W(AW), .DATA_W(DW5), .TAG_W(TW)) u_dut5 (
        .clk_i(clk), .rst_i(rst),
        .cu_req_valid_i(d5_req_zero), .cu_req_rw_i(d5_req_zero), .cu_req_addr_i(d5_addr_zero),
        .cu_req_byteen_i(d5_be_zero), .cu_req_data_i(d5_data_zero), .cu_req_tag_i(d5_tag_zero),
        .cu_req_ready_o(d5_cu_req_ready),
        .l2_req_valid_o(d5_l2_req_valid), .l2_req_rw_o(d5_l2_req_rw), .l2_req_addr_o(d5_l2_req_addr),
        .l2_req_byteen_o(d5_l2_req_byteen), .l2_req_data_o(d5_l2_req_data), .l2_req_tag_o(d5_l2_req_tag),
        .l2_req_ready_i(1'b1),
        .l2_rsp_valid_i(d5_l2_rsp_valid), .l2_rsp_data_i(d5_l2_rsp_data), .l2_rsp_tag_i(d5_l2_rsp_tag),
        .l2_rsp_ready_o(d5_l2_rsp_ready),
        .cu_rsp_valid_o(d5_cu_rsp_valid), .cu_rsp_data_o(d5_cu_rsp_data), .cu_rsp_tag_o(d5_cu_rsp_tag),
        .cu_rsp_ready_i(d5_cu_rsp_ready), .err_o(d5_err)
    );

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    endtask

    function automatic req_payload_t mk_req(input int id, input logic rw,
                                            input logic [AW-1:0] addr, input logic [TW-1:0] tag);
        req_payload_t  p;
        logic [SW-1:0] sid;
        sid      = SW'(id);
        p.rw     = rw;
        p.addr   = addr;
        p.byteen = BW'({8'hB0, tag});
        p.data   = DW'({32'hDA7A_0000, 6'd0, addr});
        p.tag    = {sid, tag};
        return p;
    endfunction

    task automatic drive_req(input int i, input logic rw, input logic [AW-1:0] addr, input logic [TW-1:0] tag);
        req_payload_t p;
        p = mk_req(i, rw, addr, tag);
        cu_req_valid[i]            = 1'b1;
        cu_req_rw[i]               = rw;
        cu_req_addr[i*AW +: AW]    = addr;
        cu_req_byteen[i*BW +: BW]  = p.byteen;
        cu_req_data[i*DW +: DW]    = p.data;
        cu_req_tag[i*TW +: TW]     = tag;
    endtask

    task automatic push_rsp(input int dest, input logic [DW-1:0] data, input logic [TW-1:0] tag);
        rsp_exp_t e;
        e.dest   = SW'(dest);
        e.p.data = data;
        e.p.tag  = tag;
        exp_rsp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // L2 request monitor: every accepted L2 request must match the queue head.
    always @(negedge clk) begin
        req_payload_t e;
        if (!rst && l2_req_valid && l2_req_ready) begin
            chk("l2_req_expected", DW'(exp_req_q.size() != 0), DW'(1));
            if (exp_req_q.size() != 0) begin
                e = exp_req_q.pop_front();
                chk("l2_req_tag", DW'(l2_req_tag), DW'(e.tag));
                chk("l2_req_addr", DW'(l2_req_addr), DW'(e.addr));
                chk("l2_req_rw", DW'(l2_req_rw), DW'(e.rw));
                chk("l2_req_byteen", DW'(l2_req_byteen), DW'(e.byteen));
                chk("l2_req_data", l2_req_data, e.data);
            end
        end
    end

    // CU response monitor: every delivered response must match the queue head.
    always @(negedge clk) begin
        rsp_exp_t e;
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                if (cu_rsp_valid[i] && cu_rsp_ready[i]) begin
                    chk("cu_rsp_expected", DW'(exp_rsp_q.size() != 0), DW'(1));
                    if (exp_rsp_q.size() != 0) begin
                        e = exp_rsp_q.pop_front();
                        chk("cu_rsp_dest", DW'(i), DW'(e.dest));
                        chk("cu_rsp_tag", DW'(cu_rsp_tag), DW'(e.p.tag));
                        chk("cu_rsp_data", cu_rsp_data, e.p.data);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int id;
        cu_req_valid = '0; cu_req_rw = '0; cu_req_addr = '0; cu_req_byteen = '0;
        cu_req_data = '0; cu_req_tag = '0; l2_req_ready = 1'b1;
        l2_rsp_valid = 1'b0; l2_rsp_data = '0; l2_rsp_tag = '0; cu_rsp_ready = '1;
        d5_req_zero = '0; d5_addr_zero = '0; d5_be_zero = '0; d5_data_zero = '0; d5_tag_zero = '0;
        d5_l2_rsp_valid = 1'b0; d5_l2_rsp_data = '0; d5_l2_rsp_tag = '0; d5_cu_rsp_ready = '1;

        repeat (2) step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_l2_req_valid", DW'(l2_req_valid), DW'(0));
        chk("rst_cu_rsp_valid", DW'(cu_rsp_valid), DW'(0));
        chk("rst_err", DW'(err), DW'(0));
        chk("rst_cu_req_ready", DW'(cu_req_ready), DW'(0));
        chk("rst_d5_idle", DW'({d5_l2_req_valid, d5_cu_req_ready, d5_err}), DW'(0));

        // Single requester CU2, then ptr=3 must favour CU3 over CU0.
        step(); drive_req(2, 1'b0, 26'h100, 8'h05); exp_req_q.push_back(mk_req(2, 1'b0, 26'h100, 8'h05));
        @(negedge clk); chk("single_ready", DW'(cu_req_ready), DW'(4'b0100));
        step(); cu_req_valid = '0;
        @(negedge clk);
        chk("single_l2_valid", DW'(l2_req_valid), DW'(1));
        chk("single_l2_tag", DW'(l2_req_tag), DW'(10'h205));
        step(); drive_req(0, 1'b1, 26'h200, 8'h10); drive_req(3, 1'b0, 26'h300, 8'h13);
        exp_req_q.push_back(mk_req(3, 1'b0, 26'h300, 8'h13));
        @(negedge clk); chk("ptr3_ready", DW'(cu_req_ready), DW'(4'b1000));
        step(); cu_req_valid[3] = 1'b0; exp_req_q.push_back(mk_req(0, 1'b1, 26'h200, 8'h10));
        @(negedge clk); chk("ptr0_ready", DW'(cu_req_ready), DW'(4'b0001));
        step(); cu_req_valid = '0;
        step(); @(negedge clk); chk("idle_l2_valid", DW'(l2_req_valid), DW'(0));

        // All four valid with ptr=1: grants 1,2,3,0,1,2,3,0 back to back.
        step();
        for (int i = 0; i < N; i++) drive_req(i, i[0], AW'(26'h40 + 16 * i), TW'(8'h30 + i));
        for (int k = 0; k < 8; k++) begin
            if (k > 0) step();
            id = (1 + k) % N;
            exp_req_q.push_back(mk_req(id, id[0], AW'(26'h40 + 16 * id), TW'(8'h30 + id)));
            @(negedge clk);
            chk("rr_grant", DW'(cu_req_ready), DW'(4'b0001 << id));
            if (k > 0) chk("rr_no_bubble", DW'(l2_req_valid), DW'(1));
        end
        step(); cu_req_valid = '0;
        @(negedge clk); chk("rr_last_valid", DW'(l2_req_valid), DW'(1));
        step(); @(negedge clk); chk("rr_drained", DW'(l2_req_valid), DW'(0));

        // Back-pressure: slot holds CU1 for 5 cycles, then drain+accept CU2.
        step(); l2_req_ready = 1'b0;
        drive_req(1, 1'b0, 26'h111, 8'h11); drive_req(2, 1'b1, 26'h222, 8'h22);
        exp_req_q.push_back(mk_req(1, 1'b0, 26'h111, 8'h11));
        @(negedge clk); chk("stall_first_ready", DW'(cu_req_ready), DW'(4'b0010));
        step(); cu_req_valid[1] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) step();
            @(negedge clk);
            chk("stall_ready", DW'(cu_req_ready), DW'(0));
            chk("stall_valid", DW'(l2_req_valid), DW'(1));
            chk("stall_tag", DW'(l2_req_tag), DW'(10'h111));
            chk("stall_addr", DW'(l2_req_addr), DW'(26'h111));
        end
        step(); l2_req_ready = 1'b1; exp_req_q.push_back(mk_req(2, 1'b1, 26'h222, 8'h22));
        @(negedge clk); chk("stall_release_ready", DW'(cu_req_ready), DW'(4'b0100));
        step(); cu_req_valid = '0;
        @(negedge clk); chk("stall_reload_tag", DW'(l2_req_tag), DW'(10'h222));
        step();

        // Responses: CU1 then CU3 (blocked), a third waits behind it.
        step(); cu_rsp_ready = 4'b0111; l2_rsp_valid = 1'b1; l2_rsp_tag = 10'h1AA; l2_rsp_data = DW'(32'hD1);
        push_rsp(1, DW'(32'hD1), 8'hAA);
        @(negedge clk); chk("rsp_ready_empty", DW'(l2_rsp_ready), DW'(1));
        step(); l2_rsp_tag = 10'h3BB; l2_rsp_data = DW'(32'hD3); push_rsp(3, DW'(32'hD3), 8'hBB);
        @(negedge clk);
        chk("rsp_cu1_valid", DW'(cu_rsp_valid), DW'(4'b0010));
        chk("rsp_ready_drain", DW'(l2_rsp_ready), DW'(1));
        step(); l2_rsp_tag = 10'h1CC; l2_rsp_data = DW'(32'hD5);
        for (int k = 0; k < 3; k++) begin
            if (k > 0) step();
            @(negedge clk);
            chk("rsp_cu3_hold", DW'(cu_rsp_valid), DW'(4'b1000));
            chk("rsp_blocked_ready", DW'(l2_rsp_ready), DW'(0));
            chk("rsp_cu3_tag", DW'(cu_rsp_tag), DW'(8'hBB));
        end
        step(); cu_rsp_ready[3] = 1'b1; push_rsp(1, DW'(32'hD5), 8'hCC);
        @(negedge clk); chk("rsp_unblocked_ready", DW'(l2_rsp_ready), DW'(1));
        step(); l2_rsp_valid = 1'b0;
        @(negedge clk); chk("rsp_third_valid", DW'(cu_rsp_valid), DW'(4'b0010));
        step(); @(negedge clk);
        chk("rsp_idle", DW'(cu_rsp_valid), DW'(0));
        chk("rsp_err_clear", DW'(err), DW'(0));

        // Out-of-range ID on the 5-requester build, then a legal ID 4.
        step(); d5_l2_rsp_valid = 1'b1; d5_l2_rsp_tag = 11'h5CC; d5_l2_rsp_data = 32'hE1;
        @(negedge clk); chk("oor_ready", DW'(d5_l2_rsp_ready), DW'(1));
        step(); d5_l2_rsp_tag = 11'h4DD; d5_l2_rsp_data = 32'hE2;
        @(negedge clk);
        chk("oor_no_valid", DW'(d5_cu_rsp_valid), DW'(0));
        chk("oor_err_set", DW'(d5_err), DW'(1));
        step(); d5_l2_rsp_valid = 1'b0;
        @(negedge clk);
        chk("id4_valid", DW'(d5_cu_rsp_valid), DW'(5'b10000));
        chk("id4_tag", DW'(d5_cu_rsp_tag), DW'(8'hDD));
        chk("id4_data", DW'(d5_cu_rsp_data), DW'(32'hE2));
        for (int k = 0; k < 3; k++) begin
            step(); @(negedge clk); chk("oor_err_sticky", DW'(d5_err), DW'(1));
        end

        // Fill both slots, reset for one cycle, then ptr must restart at CU0.
        step(); l2_req_ready = 1'b0; drive_req(1, 1'b0, 26'h0AB, 8'h44);
        cu_rsp_ready = 4'b1011; l2_rsp_valid = 1'b1; l2_rsp_tag = 10'h2EE; l2_rsp_data = DW'(32'hF0);
        @(negedge clk); chk("prerst_ready", DW'(cu_req_ready), DW'(4'b0010));
        step(); cu_req_valid = '0; l2_rsp_valid = 1'b0;
        @(negedge clk);
        chk("prerst_req_full", DW'(l2_req_valid), DW'(1));
        chk("prerst_rsp_full", DW'(cu_rsp_valid), DW'(4'b0100));
        step(); rst = 1'b1;
        step(); rst = 1'b0;
        @(negedge clk);
        chk("postrst_req_valid", DW'(l2_req_valid), DW'(0));
        chk("postrst_rsp_valid", DW'(cu_rsp_valid), DW'(0));
        chk("postrst_err", DW'(err), DW'(0));
        chk("postrst_d5_err", DW'(d5_err), DW'(0));
        step(); l2_req_ready = 1'b1; cu_rsp_ready = '1;
        for (int i = 0; i < N; i++) drive_req(i, 1'b1, AW'(26'h500 + i), TW'(8'h60 + i));
        exp_req_q.push_back(mk_req(0, 1'b1, 26'h500, 8'h60));
        @(negedge clk); chk("postrst_grant_cu0", DW'(cu_req_ready), DW'(4'b0001));
        step(); cu_req_valid = '0;
        step(); step();
        @(negedge clk);
        chk("req_queue_empty", DW'(exp_req_q.size()), DW'(0));
        chk("rsp_queue_empty", DW'(exp_rsp_q.size()), DW'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
